// File: rtl/dsrcd_load.sv
// dsrcd_load: gathers two 32-bit source beats into one 64-bit phrase,
// {srcdhi, srcdlo}, for the adder B operand. It also holds the intensity and Z
// increment registers.
// Optional feature: define DSRCD_GOURAUD_EN to enable per-pixel intensity
// stepping. When enabled, a step adds iinc[15:0] to each of the four 16-bit
// lanes of a full phrase. When the macro is undefined, gour_step is ignored
// and no lane adders exist.
module dsrcd_load (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic [31:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic        reg_we,
    input  logic        reg_sel,
    input  logic [31:0] reg_d,
    output logic        phrase_valid,
    input  logic        phrase_take,
    input  logic        gour_step,
    output logic [31:0] srcdlo,
    output logic [31:0] srcdhi,
    output logic [31:0] iinc,
    output logic [31:0] zinc
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t      state_r;
    logic        din_ready_r;
    logic        phrase_valid_r;
    logic [31:0] srcdlo_r;
    logic [31:0] srcdhi_r;
    logic [31:0] iinc_r;
    logic [31:0] zinc_r;
    logic        beat_s;

`ifdef DSRCD_GOURAUD_EN
    // Adds one increment to each 16-bit lane. Each sum is truncated to 16 bits,
    // so a carry never crosses into the next lane.
    function automatic logic [63:0] lane_add(input logic [63:0] phrase,
                                             input logic [15:0] inc);
        logic [63:0] sum;
        sum[15:0]  = phrase[15:0]  + inc;
        sum[31:16] = phrase[31:16] + inc;
        sum[47:32] = phrase[47:32] + inc;
        sum[63:48] = phrase[63:48] + inc;
        return sum;
    endfunction

    logic [63:0] stepped_s;
    assign stepped_s = lane_add({srcdhi_r, srcdlo_r}, iinc_r[15:0]);
`else
    logic gour_step_unused_s;
    assign gour_step_unused_s = gour_step;
`endif

    // A beat moves only when it is offered and the block can take it.
    assign beat_s = din_valid & din_ready_r;

    // Phrase assembly FSM. It also keeps the increment registers and the
    // registered handshake outputs.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_r        <= EMPTY;
            din_ready_r    <= 1'b1;
            phrase_valid_r <= 1'b0;
            srcdlo_r       <= 32'h0000_0000;
            srcdhi_r       <= 32'h0000_0000;
            iinc_r         <= 32'h0000_0000;
            zinc_r         <= 32'h0000_0000;
        end else begin
            // Register writes are honoured in every state. A step in the same
            // cycle still sees the old iinc_r, because that is the value
            // present before the edge.
            if (reg_we) begin
                if (reg_sel) begin
                    zinc_r <= reg_d;
                end else begin
                    iinc_r <= reg_d;
                end
            end

            case (state_r)
                EMPTY: begin
                    if (beat_s) begin
                        srcdlo_r       <= din;
                        state_r        <= HALF;
                        din_ready_r    <= 1'b1;
                        phrase_valid_r <= 1'b0;
                    end
                end
                HALF: begin
                    if (beat_s) begin
                        srcdhi_r       <= din;
                        state_r        <= FULL;
                        din_ready_r    <= 1'b0;
                        phrase_valid_r <= 1'b1;
                    end
                end
                FULL: begin
                    // A take wins over a step. The phrase halves keep their
                    // values until new beats overwrite them.
                    if (phrase_take) begin
                        state_r        <= EMPTY;
                        din_ready_r    <= 1'b1;
                        phrase_valid_r <= 1'b0;
`ifdef DSRCD_GOURAUD_EN
                    end else if (gour_step) begin
                        srcdlo_r <= stepped_s[31:0];
                        srcdhi_r <= stepped_s[63:32];
`endif
                    end
                end
                default: begin
                    state_r        <= EMPTY;
                    din_ready_r    <= 1'b1;
                    phrase_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign din_ready    = din_ready_r;
    assign phrase_valid = phrase_valid_r;
    assign srcdlo       = srcdlo_r;
    assign srcdhi       = srcdhi_r;
    assign iinc         = iinc_r;
    assign zinc         = zinc_r;

endmodule

// File: tb/tb_dsrcd_load.sv
// Directed self-checking bench for dsrcd_load. When DSRCD_GOURAUD_EN is
// defined, the step scenarios expect the lane sums; otherwise they expect the
// phrase to be left unchanged.
module tb_dsrcd_load;

`ifdef DSRCD_GOURAUD_EN
    localparam bit GOUR_EN = 1'b1;
`else
    localparam bit GOUR_EN = 1'b0;
`endif

    logic        sys_clk;
    logic        reset;
    logic [31:0] din;
    logic        din_valid;
    logic        din_ready;
    logic        reg_we;
    logic        reg_sel;
    logic [31:0] reg_d;
    logic        phrase_valid;
    logic        phrase_take;
    logic        gour_step;
    logic [31:0] srcdlo;
    logic [31:0] srcdhi;
    logic [31:0] iinc;
    logic [31:0] zinc;

    int errors = 0;
    int checks = 0;

    dsrcd_load dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .din          (din),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .reg_we       (reg_we),
        .reg_sel      (reg_sel),
        .reg_d        (reg_d),
        .phrase_valid (phrase_valid),
        .phrase_take  (phrase_take),
        .gour_step    (gour_step),
        .srcdlo       (srcdlo),
        .srcdhi       (srcdhi),
        .iinc         (iinc),
        .zinc         (zinc)
    );

    // Free-running clock, period 10.
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // Advance past one rising edge. Outputs are settled 1 time unit later,
    // and inputs are changed at that same point.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle_inputs();
        din_valid   = 1'b0;
        din         = 32'h0000_0000;
        reg_we      = 1'b0;
        reg_sel     = 1'b0;
        reg_d       = 32'h0000_0000;
        phrase_take = 1'b0;
        gour_step   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (din_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b exp 1", din_ready);
        end
        checks++;
        if (phrase_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b exp 0", phrase_valid);
        end
        checks++;
        if ({srcdhi, srcdlo, iinc, zinc} !== 128'h0) begin
            errors++; $display("FAIL reset_regs: got %h %h %h %h exp all 0", srcdhi, srcdlo, iinc, zinc);
        end
    endtask

    task automatic test_load();
        din_valid = 1'b1;
        din       = 32'h1111_2222;
        tick();
        checks++;
        if (srcdlo !== 32'h1111_2222 || phrase_valid !== 1'b0 || din_ready !== 1'b1) begin
            errors++; $display("FAIL load_lo: got lo=%h pv=%b rdy=%b exp 11112222 0 1", srcdlo, phrase_valid, din_ready);
        end
        din = 32'h3333_4444;
        tick();
        checks++;
        if (srcdhi !== 32'h3333_4444 || srcdlo !== 32'h1111_2222) begin
            errors++; $display("FAIL load_hi: got hi=%h lo=%h exp 33334444 11112222", srcdhi, srcdlo);
        end
        checks++;
        if (phrase_valid !== 1'b1 || din_ready !== 1'b0) begin
            errors++; $display("FAIL load_full: got pv=%b rdy=%b exp 1 0", phrase_valid, din_ready);
        end
    endtask

    task automatic test_full_hold();
        din_valid = 1'b1;
        din       = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (srcdlo !== 32'h1111_2222 || srcdhi !== 32'h3333_4444 || phrase_valid !== 1'b1) begin
                errors++; $display("FAIL full_hold[%0d]: got lo=%h hi=%h pv=%b exp 11112222 33334444 1", i, srcdlo, srcdhi, phrase_valid);
            end
        end
        phrase_take = 1'b1;
        tick();
        phrase_take = 1'b0;
        checks++;
        if (phrase_valid !== 1'b0 || din_ready !== 1'b1 || srcdlo !== 32'h1111_2222 || srcdhi !== 32'h3333_4444) begin
            errors++; $display("FAIL take_empty: got pv=%b rdy=%b lo=%h hi=%h exp 0 1 11112222 33334444", phrase_valid, din_ready, srcdlo, srcdhi);
        end
        din = 32'hCAFE_F00D;
        tick();
        din_valid = 1'b0;
        checks++;
        if (srcdlo !== 32'hCAFE_F00D || srcdhi !== 32'h3333_4444 || phrase_valid !== 1'b0) begin
            errors++; $display("FAIL reload_lo: got lo=%h hi=%h pv=%b exp cafef00d 33334444 0", srcdlo, srcdhi, phrase_valid);
        end
    endtask

    task automatic test_regs();
        // The block is in HALF here, so these writes also exercise a non-EMPTY state.
        reg_we  = 1'b1;
        reg_sel = 1'b0;
        reg_d   = 32'hA5A5_0001;
        tick();
        reg_sel = 1'b1;
        reg_d   = 32'h0F0F_1234;
        tick();
        reg_we = 1'b0;
        checks++;
        if (iinc !== 32'hA5A5_0001 || zinc !== 32'h0F0F_1234) begin
            errors++; $display("FAIL reg_write: got iinc=%h zinc=%h exp a5a50001 0f0f1234", iinc, zinc);
        end
        checks++;
        if (din_ready !== 1'b1 || phrase_valid !== 1'b0 || srcdlo !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL reg_state: got rdy=%b pv=%b lo=%h exp 1 0 cafef00d", din_ready, phrase_valid, srcdlo);
        end
    endtask

    task automatic test_reset_mid();
        // Reset in HALF, with competing inputs asserted in the same cycle.
        reset     = 1'b1;
        din_valid = 1'b1;
        din       = 32'h5555_6666;
        reg_we    = 1'b1;
        reg_d     = 32'h7777_8888;
        gour_step = 1'b1;
        tick();
        reset = 1'b0;
        idle_inputs();
        checks++;
        if ({srcdhi, srcdlo, iinc, zinc} !== 128'h0 || din_ready !== 1'b1 || phrase_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid: got %h %h %h %h rdy=%b pv=%b exp zeros 1 0", srcdhi, srcdlo, iinc, zinc, din_ready, phrase_valid);
        end
        din_valid = 1'b1;
        din       = 32'h0102_0304;
        tick();
        din_valid = 1'b0;
        checks++;
        if (srcdlo !== 32'h0102_0304 || srcdhi !== 32'h0000_0000 || phrase_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_lo: got lo=%h hi=%h pv=%b exp 01020304 0 0", srcdlo, srcdhi, phrase_valid);
        end
        // Complete the phrase so the block is back in EMPTY.
        din_valid = 1'b1;
        din       = 32'h0000_0000;
        tick();
        din_valid   = 1'b0;
        phrase_take = 1'b1;
        tick();
        phrase_take = 1'b0;
    endtask

    // Loads the lane pattern FFFF,0000,7FFF,1234 (lane 0 first) into a full phrase.
    task automatic load_lanes();
        din_valid = 1'b1;
        din       = 32'h0000_FFFF;
        tick();
        din = 32'h1234_7FFF;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic test_gour_step();
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
        reg_we  = 1'b1;
        reg_sel = 1'b0;
        reg_d   = 32'h0000_0001;
        tick();
        reg_we = 1'b0;
        load_lanes();
        gour_step = 1'b1;
        tick();
        gour_step = 1'b0;
        exp_lo = GOUR_EN ? 32'h0001_0000 : 32'h0000_FFFF;
        exp_hi = GOUR_EN ? 32'h1235_8000 : 32'h1234_7FFF;
        checks++;
        if (srcdlo !== exp_lo || srcdhi !== exp_hi || phrase_valid !== 1'b1) begin
            errors++; $display("FAIL step_lanes: got hi=%h lo=%h pv=%b exp %h %h 1", srcdhi, srcdlo, phrase_valid, exp_hi, exp_lo);
        end
        phrase_take = 1'b1;
        tick();
        phrase_take = 1'b0;
    endtask

    task automatic test_step_with_write();
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
        load_lanes();
        // The step must use the old iinc (1) while iinc is rewritten to 0x10.
        reg_we    = 1'b1;
        reg_sel   = 1'b0;
        reg_d     = 32'h0000_0010;
        gour_step = 1'b1;
        tick();
        reg_we = 1'b0;
        exp_lo = GOUR_EN ? 32'h0001_0000 : 32'h0000_FFFF;
        exp_hi = GOUR_EN ? 32'h1235_8000 : 32'h1234_7FFF;
        checks++;
        if (srcdlo !== exp_lo || srcdhi !== exp_hi || iinc !== 32'h0000_0010) begin
            errors++; $display("FAIL step_old_iinc: got hi=%h lo=%h iinc=%h exp %h %h 00000010", srcdhi, srcdlo, iinc, exp_hi, exp_lo);
        end
        tick();
        gour_step = 1'b0;
        exp_lo = GOUR_EN ? 32'h0011_0010 : 32'h0000_FFFF;
        exp_hi = GOUR_EN ? 32'h1245_8010 : 32'h1234_7FFF;
        checks++;
        if (srcdlo !== exp_lo || srcdhi !== exp_hi || phrase_valid !== 1'b1) begin
            errors++; $display("FAIL step_new_iinc: got hi=%h lo=%h pv=%b exp %h %h 1", srcdhi, srcdlo, phrase_valid, exp_hi, exp_lo);
        end
    endtask

    task automatic test_take_and_step();
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
        // Still FULL from the previous scenario. The take must win.
        exp_lo = GOUR_EN ? 32'h0011_0010 : 32'h0000_FFFF;
        exp_hi = GOUR_EN ? 32'h1245_8010 : 32'h1234_7FFF;
        phrase_take = 1'b1;
        gour_step   = 1'b1;
        tick();
        phrase_take = 1'b0;
        checks++;
        if (phrase_valid !== 1'b0 || din_ready !== 1'b1 || srcdlo !== exp_lo || srcdhi !== exp_hi) begin
            errors++; $display("FAIL take_step: got pv=%b rdy=%b hi=%h lo=%h exp 0 1 %h %h", phrase_valid, din_ready, srcdhi, srcdlo, exp_hi, exp_lo);
        end
        // A step in EMPTY is ignored, and a take in EMPTY is also ignored.
        phrase_take = 1'b1;
        tick();
        gour_step   = 1'b0;
        phrase_take = 1'b0;
        checks++;
        if (phrase_valid !== 1'b0 || din_ready !== 1'b1 || srcdlo !== exp_lo || srcdhi !== exp_hi) begin
            errors++; $display("FAIL step_empty: got pv=%b rdy=%b hi=%h lo=%h exp 0 1 %h %h", phrase_valid, din_ready, srcdhi, srcdlo, exp_hi, exp_lo);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_load();
        test_full_hold();
        test_regs();
        test_reset_mid();
        test_gour_step();
        test_step_with_write();
        test_take_and_step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
